// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, totals and scanout state encoding.
// Default timing is 640x480 at a 25 MHz-class pixel clock.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_TOTAL_D  =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_TOTAL_D  =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  typedef enum logic {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } state_e;

  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster position counters plus active/sync/origin decode.
// Counters hold at the origin whenever run is low.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic active,
  output logic hsync_on,
  output logic vsync_on,
  output logic origin,
  output logic wrap
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_end;
  logic          v_end;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vsync_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign origin   = (h_cnt == '0) && (v_cnt == '0);
  assign wrap     = h_end && v_end;

endmodule

// File: rtl/pixel_scanout.sv
// Display scanout: waits for FIFO fill, then streams pixels with
// syncs, all outputs one clock behind the raster position.
module pixel_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] fifo_data,
  input  logic        fifo_empty,
  output logic        rd_en,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        underflow
);

  state_e state_q;
  state_e state_d;
  logic   run;
  logic   active;
  logic   hsync_on;
  logic   vsync_on;
  logic   origin;
  logic   wrap;
  logic   rd_q;

  assign run = (state_q == RUN);

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .active   (active),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on),
    .origin   (origin),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_FILL;
    else      state_q <= state_d;
  end

  // en is only honoured at the last clock of a frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FILL: if (en && !fifo_empty) state_d = RUN;
      RUN:       if (wrap && !en)       state_d = WAIT_FILL;
      default:   state_d = WAIT_FILL;
    endcase
  end

  assign rd_en = run && active && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      rd_q        <= rd_en;
      hsync       <= !(run && hsync_on);
      vsync       <= !(run && vsync_on);
      blank       <= !(run && active);
      frame_start <= run && origin;
      if (run && active && fifo_empty)
        underflow <= 1'b1;
    end
  end

  // FIFO word arrives the clock after rd_en, in step with the syncs
  assign rgb = rd_q ? fifo_data : '0;

endmodule

// File: tb/tb_pixel_scanout.sv
// Randomized scoreboard bench for pixel_scanout on a reduced raster
// against a frame-position reference model.
module tb_pixel_scanout;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [23:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        rd_en;
  logic [23:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic        underflow;

  always #5 clk = ~clk;

  pixel_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .rd_en       (rd_en),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pe = 100;

  function automatic logic [23:0] word(int k);
    logic [31:0] x;
    x = k * 32'h9E3779B1 + 32'h005A5A5A;
    return x[31:8];
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h",
               nm, $time, a, x);
    end
  endtask

  // display FIFO: word k returned the clock after the k-th read
  int rcnt = 0;
  always @(posedge clk) begin
    if (rd_en) begin
      fifo_data <= word(rcnt);
      rcnt <= rcnt + 1;
    end
  end

  // reference: one position index p over the whole frame
  int   p = 0;
  bit   m_run = 0;
  bit   m_uf = 0;
  int   ridx = 0;
  int   mh, mv;
  bit   mact;
  exp_t me;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0;
      p = 0;
      m_uf = 0;
      sb.delete();
    end else begin
      mh = p % HT;
      mv = p / HT;
      mact = m_run && mh < HA && mv < VA;
      me.bl = !mact;
      me.hs = !(m_run && mh >= HA + HF && mh < HA + HF + HS);
      me.vs = !(m_run && mv >= VA + VF && mv < VA + VF + VS);
      me.fs = m_run && p == 0;
      if (mact && fifo_empty) m_uf = 1;
      me.uf = m_uf;
      if (mact && !fifo_empty) begin
        me.rgb = word(ridx);
        ridx++;
      end else begin
        me.rgb = '0;
      end
      sb.push_back(me);
      if (m_run) begin
        if (p == FR - 1) begin
          p = 0;
          m_run = en;
        end else begin
          p++;
        end
      end else if (en && !fifo_empty) begin
        m_run = 1;
      end
    end
  end

  exp_t ce;
  bit   erd;
  always @(negedge clk) begin
    if (rst) begin
      erd = m_run && (p % HT) < HA && (p / HT) < VA
            && !fifo_empty;
      chk("rd_en", 32'(rd_en), 32'(erd));
      if (sb.size() > 0) begin
        ce = sb.pop_front();
        chk("rgb", 32'(rgb), 32'(ce.rgb));
        chk("hsync", 32'(hsync), 32'(ce.hs));
        chk("vsync", 32'(vsync), 32'(ce.vs));
        chk("blank", 32'(blank), 32'(ce.bl));
        chk("frame_start", 32'(frame_start), 32'(ce.fs));
        chk("underflow", 32'(underflow), 32'(ce.uf));
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      fifo_empty = ($urandom_range(99) < pe);
    end
  endtask

  task automatic idle_chk(string nm);
    #1;
    chk({nm, "_blank"}, 32'(blank), 32'd1);
    chk({nm, "_hsync"}, 32'(hsync), 32'd1);
    chk({nm, "_vsync"}, 32'(vsync), 32'd1);
    chk({nm, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({nm, "_rgb"}, 32'(rgb), 32'd0);
  endtask

  initial begin
    en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    pe = 100;
    step(60);
    idle_chk("fill_wait");
    chk("fill_wait_uf", 32'(underflow), 32'd0);

    pe = 0;
    step(2 * FR + 20);
    chk("clean_reads", 32'(rcnt), 32'(ridx));

    pe = 8;
    step(FR);

    pe = 3;
    step(40);
    en = 1'b0;
    step(FR + 30);
    idle_chk("en_off");

    en = 1'b1;
    pe = 5;
    step(FR / 2 + 7);
    @(posedge clk);
    #2 rst = 1'b0;
    idle_chk("async_rst");
    chk("async_rst_fs", 32'(frame_start), 32'd0);
    chk("async_rst_uf", 32'(underflow), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    fifo_empty = 1'b1;
    rst = 1'b1;
    pe = 100;
    step(30);
    idle_chk("rst_hold");

    pe = 0;
    step(FR + 10);
    chk("total_reads", 32'(rcnt), 32'(ridx));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
